// File: rtl/stepper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : stepper_pkg                                                     |
// | Purpose  : Shared definitions for the door-lock stepper drive: coil phase  |
// |            patterns, monitor state encoding, step classification and      |
// |            phase rotation helpers. The driver uses the same constants.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package stepper_pkg;

  // Coil phase patterns in forward (open) order. The forward sequence walks
  // the single set bit towards the LSB.
  localparam logic [3:0] PH_A    = 4'b1000;
  localparam logic [3:0] PH_B    = 4'b0100;
  localparam logic [3:0] PH_C    = 4'b0010;
  localparam logic [3:0] PH_D    = 4'b0001;
  localparam logic [3:0] PH_HOME = PH_A;

  typedef enum logic [0:0] {
    TRACK = 1'b0,
    FAULT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_BAD  = 2'd3
  } step_kind_t;

  // Forward neighbour: 1000 -> 0100 -> 0010 -> 0001 -> 1000
  function automatic logic [3:0] rot_r1(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // Reverse neighbour: 1000 -> 0001 -> 0010 -> 0100 -> 1000
  function automatic logic [3:0] rot_l1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage : stepper_pkg
`default_nettype wire

// File: rtl/stepper_phase_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: stepper_phase_monitor_if                                        |
// | Purpose  : Bundle between the stepper drive side and the phase monitor.   |
// |   phase_in   : coil phase bus (asynchronous to the monitor clock)          |
// |   clear      : synchronous position zero / fault exit                      |
// |   position   : step count from home                                        |
// |   step_pulse : one-cycle pulse per accepted step                           |
// |   dir        : direction of last accepted step (1 = open)                  |
// |   at_open    : position at or beyond fully-open travel                     |
// |   at_home    : position is zero                                            |
// |   fault      : sticky illegal/skipped step indication                      |
// | Modports : master = drive/controller side, slave = monitor                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface stepper_phase_monitor_if #(
  parameter int POS_W = 8
);
  logic [3:0]       phase_in;
  logic             clear;
  logic [POS_W-1:0] position;
  logic             step_pulse;
  logic             dir;
  logic             at_open;
  logic             at_home;
  logic             fault;

  modport master (
    output phase_in, clear,
    input  position, step_pulse, dir, at_open, at_home, fault
  );

  modport slave (
    input  phase_in, clear,
    output position, step_pulse, dir, at_open, at_home, fault
  );
endinterface : stepper_phase_monitor_if
`default_nettype wire

// File: rtl/stepper_phase_monitor_phase_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : phase_sync_filter                                               |
// | Purpose  : Two-flop synchroniser for the coil phase bus plus a stability   |
// |            counter that raises cand_valid for exactly one cycle once the   |
// |            synchronised pattern has held for STABLE_CYCLES cycles.         |
// | Ports    : clk, reset (async, active low), phase_in[3:0] (async),          |
// |            clear (zeroes the counter), sph[3:0] (synchronised phase),      |
// |            cand_valid (one-cycle candidate strobe)                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module phase_sync_filter
  import stepper_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [3:0] phase_in,
  input  wire logic       clear,
  output logic      [3:0] sph,
  output logic            cand_valid
);

  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [7:0] stable_cnt;

  // The counter is cleared on the same edge that loads a new value into
  // sync2, so stable_cnt reads 0 in the first cycle sph shows a new pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= PH_HOME;
      sync2      <= PH_HOME;
      stable_cnt <= 8'd0;
    end else begin
      sync1 <= phase_in;
      sync2 <= sync1;
      if (clear || (sync1 != sync2)) begin
        stable_cnt <= 8'd0;
      end else if (stable_cnt != C_STABLE) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  assign sph = sync2;

  // Strobe in the cycle whose closing edge takes the counter to STABLE_CYCLES;
  // the consumer registers its decision on that same edge. Saturation keeps
  // this to one strobe per stable period.
  assign cand_valid = (sync1 == sync2) && (stable_cnt == (C_STABLE - 8'd1));

endmodule : phase_sync_filter
`default_nettype wire

// File: rtl/stepper_phase_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stepper_phase_monitor                                           |
// | Purpose  : Read-back monitor for the door-lock stepper. Decodes steps and  |
// |            direction from the coil phase bus, tracks shaft position,       |
// |            flags skipped/illegal patterns and reports open/home travel.    |
// | Ports    : clk, reset (async, active low),                                 |
// |            bus (slave): phase_in, clear in; position, step_pulse, dir,     |
// |            at_open, at_home, fault out                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stepper_phase_monitor
  import stepper_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W         = 8,
  parameter int OPEN_STEPS    = 100
) (
  input  wire logic               clk,
  input  wire logic               reset,
  stepper_phase_monitor_if.slave  bus
);

  localparam logic [POS_W-1:0] OPEN_POS = POS_W'(OPEN_STEPS);
  localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic [3:0]       sph;
  logic             cand_valid;

  state_t           state;
  logic [3:0]       accepted;
  logic [POS_W-1:0] position;
  logic             step_pulse;
  logic             dir;
  logic             fault;
  logic             at_open;
  logic             at_home;

  step_kind_t       kind;
  logic [POS_W-1:0] pos_next;

  phase_sync_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .phase_in   (bus.phase_in),
    .clear      (bus.clear),
    .sph        (sph),
    .cand_valid (cand_valid)
  );

  // Classify the candidate against the accepted phase. The accepted phase is
  // always one-hot, so a one-hot candidate that is neither neighbour must be
  // the opposite coil, i.e. a skipped step.
  always_comb begin
    kind = STEP_NONE;
    if (cand_valid && (sph != accepted)) begin
      if (!is_onehot(sph)) begin
        kind = STEP_BAD;
      end else if (sph == rot_r1(accepted)) begin
        kind = STEP_FWD;
      end else if (sph == rot_l1(accepted)) begin
        kind = STEP_REV;
      end else begin
        kind = STEP_BAD;
      end
    end
  end

  // Next position feeds both the position register and the travel flags so
  // all three change on the same edge.
  always_comb begin
    pos_next = position;
    if (bus.clear) begin
      pos_next = '0;
    end else if (state == TRACK) begin
      case (kind)
        STEP_FWD: if (position != POS_MAX) pos_next = position + POS_ONE;
        STEP_REV: if (position != '0)      pos_next = position - POS_ONE;
        default:  pos_next = position;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= TRACK;
      accepted   <= PH_HOME;
      position   <= '0;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      fault      <= 1'b0;
      at_open    <= 1'b0;
      at_home    <= 1'b1;
    end else begin
      position   <= pos_next;
      at_open    <= (pos_next >= OPEN_POS);
      at_home    <= (pos_next == '0);
      step_pulse <= 1'b0;
      if (bus.clear) begin
        // Clear overrides any candidate in the same cycle; resynchronise the
        // accepted phase to whatever the coils show now.
        state    <= TRACK;
        fault    <= 1'b0;
        accepted <= is_onehot(sph) ? sph : PH_HOME;
      end else begin
        case (state)
          TRACK: begin
            case (kind)
              STEP_FWD: begin
                dir        <= 1'b1;
                step_pulse <= 1'b1;
                accepted   <= sph;
              end
              STEP_REV: begin
                dir        <= 1'b0;
                step_pulse <= 1'b1;
                accepted   <= sph;
              end
              STEP_BAD: begin
                fault <= 1'b1;
                state <= FAULT;
              end
              default: ;
            endcase
          end
          FAULT: begin
            fault <= 1'b1;
          end
          default: begin
            state <= FAULT;
            fault <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.position   = position;
  assign bus.step_pulse = step_pulse;
  assign bus.dir        = dir;
  assign bus.fault      = fault;
  assign bus.at_open    = at_open;
  assign bus.at_home    = at_home;

endmodule : stepper_phase_monitor
`default_nettype wire

// File: tb/tb_stepper_phase_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stepper_phase_monitor                                        |
// | Purpose  : Directed bench for stepper_phase_monitor. Stimulus pushes the   |
// |            expected step (direction, position, cycle) into a queue; a      |
// |            monitor pops and compares on every step_pulse.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stepper_phase_monitor;
  import stepper_pkg::*;

  localparam int STABLE = 4;
  localparam int LAT    = 2 + STABLE;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stepper_phase_monitor_if #(.POS_W(8)) bus ();

  stepper_phase_monitor #(
    .STABLE_CYCLES (STABLE),
    .POS_W         (8),
    .OPEN_STEPS    (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int d;
    int pos;
    int cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  int         ph_idx   = 0;
  int         pos_model = 0;
  logic [3:0] seq [4];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.step_pulse === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step_pulse: got pulse at cycle %0d, expected none (pos=%0d)",
                 cycle, bus.position);
      end else begin
        e = sb_q.pop_front();
        check("step_dir", int'(bus.dir), e.d);
        check("step_position", int'(bus.position), e.pos);
        check("step_cycle", cycle, e.cyc);
      end
    end
  end

  // Drive a phase right after an edge and hold it for 'hold' edges.
  task automatic apply(input logic [3:0] ph, input int hold,
                       input bit pulse, input int d, input int pos);
    @(posedge clk);
    #1;
    bus.phase_in = ph;
    if (pulse) sb_q.push_back('{d, pos, cycle + LAT});
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic fwd(input int hold);
    ph_idx    = (ph_idx + 1) % 4;
    pos_model = (pos_model < 255) ? pos_model + 1 : 255;
    apply(seq[ph_idx], hold, 1'b1, 1, pos_model);
  endtask

  task automatic rev(input int hold);
    ph_idx    = (ph_idx + 3) % 4;
    pos_model = (pos_model > 0) ? pos_model - 1 : 0;
    apply(seq[ph_idx], hold, 1'b1, 0, pos_model);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    seq[0] = PH_A; seq[1] = PH_B; seq[2] = PH_C; seq[3] = PH_D;
    reset        = 1'b0;
    bus.phase_in = PH_A;
    bus.clear    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_position", int'(bus.position), 0);
    check("rst_at_home", int'(bus.at_home), 1);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_position", int'(bus.position), 0);
    check("idle_at_home", int'(bus.at_home), 1);
    check("idle_fault", int'(bus.fault), 0);
    check("idle_at_open", int'(bus.at_open), 0);
    check("idle_dir", int'(bus.dir), 0);

    // Forward 0100, 0010, 0001, 1000
    for (int i = 0; i < 4; i++) fwd(10);
    check("fwd4_position", int'(bus.position), 4);
    check("fwd4_dir", int'(bus.dir), 1);
    check("fwd4_at_home", int'(bus.at_home), 0);

    // Up to fully-open travel
    for (int k = 5; k <= 100; k++) begin
      fwd(8);
      if (k == 99) check("pos99_at_open", int'(bus.at_open), 0);
    end
    check("open_position", int'(bus.position), 100);
    check("open_at_open", int'(bus.at_open), 1);

    // Three reverse steps: 0001, 0010, 0100
    for (int i = 0; i < 3; i++) rev(10);
    check("rev_position", int'(bus.position), 97);
    check("rev_at_open", int'(bus.at_open), 0);
    check("rev_dir", int'(bus.dir), 0);

    // Back to 1000, then a 2-cycle glitch to 0100
    rev(10);
    @(posedge clk);
    #1 bus.phase_in = PH_B;
    repeat (2) @(posedge clk);
    #1 bus.phase_in = PH_A;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_position", int'(bus.position), 96);
    check("glitch_fault", int'(bus.fault), 0);

    // Skipped step from 1000 to 0010, then an illegal pattern, then a legal one
    apply(PH_C, 10, 1'b0, 0, 0);
    check("skip_fault", int'(bus.fault), 1);
    check("skip_position", int'(bus.position), 96);
    apply(4'b1100, 10, 1'b0, 0, 0);
    check("illegal_fault", int'(bus.fault), 1);
    apply(PH_B, 10, 1'b0, 0, 0);
    check("fault_ignore_position", int'(bus.position), 96);
    apply(PH_C, 10, 1'b0, 0, 0);
    pulse_clear();
    repeat (2) @(posedge clk);
    #1;
    check("clear_fault", int'(bus.fault), 0);
    check("clear_position", int'(bus.position), 0);
    check("clear_at_home", int'(bus.at_home), 1);
    ph_idx    = 2;
    pos_model = 0;
    fwd(10);
    check("post_clear_position", int'(bus.position), 1);

    // Climb to 37, then asynchronous reset between edges
    for (int k = 2; k <= 37; k++) fwd(8);
    check("pre_reset_position", int'(bus.position), 37);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_position", int'(bus.position), 0);
    check("async_rst_at_home", int'(bus.at_home), 1);
    check("async_rst_dir", int'(bus.dir), 0);
    check("async_rst_pulse", int'(bus.step_pulse), 0);
    bus.phase_in = PH_A;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    ph_idx    = 0;
    pos_model = 0;
    repeat (10) @(posedge clk);
    #1;

    // Clear coincident with a candidate evaluation
    for (int i = 0; i < 3; i++) fwd(10);
    check("pre_coinc_position", int'(bus.position), 3);
    @(posedge clk);
    #1 bus.phase_in = PH_A;
    repeat (LAT - 1) @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("coinc_position", int'(bus.position), 0);
    check("coinc_fault", int'(bus.fault), 0);
    ph_idx    = 0;
    pos_model = 0;
    fwd(10);
    check("post_coinc_position", int'(bus.position), 1);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stepper_phase_monitor
`default_nettype wire
